// File: rtl/nibble_cmp_seq_pkg.sv
// Shared definitions for the nibble comparison sequencer: result encodings and FSM states.
// The one-hot {gt, eq, lt} encoding is the same one the 4-bit comparator datapath uses.
package cmp_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_cmp_seq_if.sv
// Request/response bundle between a control unit (master) and the comparison sequencer (slave).
interface nibble_cmp_seq_if #(
  parameter int NIBBLES = 4
);

  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [2:0]   result;
  logic [4:0]   nib_cnt;

  modport master (
    output start, a, b,
    input  busy, done, result, nib_cnt
  );

  modport slave (
    input  start, a, b,
    output busy, done, result, nib_cnt
  );

endinterface

// File: rtl/nibble_cmp_seq_cmp4.sv
// Combinational 4-bit magnitude comparator producing a one-hot {gt, eq, lt} result.
module cmp4
  import cmp_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [2:0] q
);

  always_comb begin
    if (a > b) begin
      q = CMP_GT;
    end else if (a < b) begin
      q = CMP_LT;
    end else begin
      q = CMP_EQ;
    end
  end

endmodule

// File: rtl/nibble_cmp_seq.sv
// Multi-word magnitude comparator: walks the captured operands MSB nibble first through one
// shared cmp4 and stops at the first unequal nibble.
module nibble_cmp_seq
  import cmp_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  nibble_cmp_seq_if.slave bus
);

  localparam int              W       = 4 * NIBBLES;
  localparam int              IDXW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NIBBLES - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q;
  logic [IDXW-1:0] idx_q;
  logic [2:0]      result_q;
  logic [4:0]      nib_cnt_q;

  logic [3:0]      nib_a, nib_b;
  logic [2:0]      cmp_res;
  logic            accept;
  logic            last_nib;
  logic            decided;

  // One comparator, fed by an indexed part-select of the captured operands.
  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  cmp4 u_cmp4 (
    .a (nib_a),
    .b (nib_b),
    .q (cmp_res)
  );

  assign accept   = (state_q == S_IDLE) && bus.start;
  assign last_nib = (idx_q == '0);
  assign decided  = (cmp_res != CMP_EQ) || last_nib;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_CMP;
      S_CMP:   if (decided)   state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: the operand registers are plain flops, not a RAM, so they reset to 0 with the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      result_q  <= CMP_NONE;
      nib_cnt_q <= '0;
    end else if (accept) begin
      a_q       <= bus.a;
      b_q       <= bus.b;
      idx_q     <= IDX_TOP;
      result_q  <= CMP_NONE;
      nib_cnt_q <= '0;
    end else if (state_q == S_CMP) begin
      nib_cnt_q <= nib_cnt_q + 5'd1;
      if (cmp_res != CMP_EQ) begin
        result_q <= cmp_res;
      end else if (last_nib) begin
        result_q <= CMP_EQ;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  // result and nib_cnt are held registers; they only change on the next accepted start.
  always_comb begin
    bus.busy    = (state_q == S_CMP) || (state_q == S_DONE);
    bus.done    = (state_q == S_DONE);
    bus.result  = result_q;
    bus.nib_cnt = nib_cnt_q;
  end

endmodule

// File: tb/tb_nibble_cmp_seq.sv
// Directed and swept checks of nibble_cmp_seq with NIBBLES=4: results, latency, reset abort,
// start-while-busy and back-to-back operation.
module tb_nibble_cmp_seq;
  import cmp_pkg::*;

  localparam int NIBBLES = 4;

  logic clk = 1'b0;
  logic rst;

  nibble_cmp_seq_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_cmp_seq #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Present one request, then measure the cycle done appears in and the held outputs.
  // Returns just after the edge that brings the FSM back to IDLE, so a following call is back-to-back.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [2:0] exp_res, input int exp_k);
    int lat;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= NIBBLES + 3; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, " done_cycle"}, lat, exp_k + 1);
    check({tag, " result"}, {29'd0, bus.result}, {29'd0, exp_res});
    check({tag, " nib_cnt"}, {27'd0, bus.nib_cnt}, exp_k);
    @(posedge clk);
    #1 check({tag, " idle_after"}, {31'd0, bus.busy}, 0);
  endtask

  // Reference: ordinary magnitude compare, k = position of first differing nibble from the MSB.
  task automatic ref_model(input logic [15:0] a, input logic [15:0] b,
                           output logic [2:0] res, output int k);
    logic [15:0] x;
    res = (a > b) ? CMP_GT : (a < b) ? CMP_LT : CMP_EQ;
    x   = a ^ b;
    k   = NIBBLES;
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      if (x[4*i +: 4] != 4'h0) begin
        k = NIBBLES - i;
        break;
      end
    end
  endtask

  initial begin
    int          d0;
    logic [15:0] ra, rb;
    logic [2:0]  eres;
    int          ek;
    int          p;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst busy",    {31'd0, bus.busy},    0);
    check("rst done",    {31'd0, bus.done},    0);
    check("rst result",  {29'd0, bus.result},  {29'd0, CMP_NONE});
    check("rst nib_cnt", {27'd0, bus.nib_cnt}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle no start busy", {31'd0, bus.busy}, 0);

    run("equal",     16'h1234, 16'h1234, CMP_EQ, 4);
    run("msb",       16'h9000, 16'h1FFF, CMP_GT, 1);
    run("lsb",       16'h12A4, 16'h12A5, CMP_LT, 4);

    // Held outputs survive idle cycles.
    repeat (3) @(negedge clk);
    check("hold result",  {29'd0, bus.result},  {29'd0, CMP_LT});
    check("hold nib_cnt", {27'd0, bus.nib_cnt}, 4);

    // Start while busy: only the first request is served.
    d0        = done_cnt;
    bus.a     = 16'h0050;
    bus.b     = 16'h0040;
    bus.start = 1'b1;
    @(posedge clk);
    #1 begin bus.a = 16'hFFFF; bus.b = 16'h0000; end
    @(posedge clk);
    #1 begin bus.a = 16'h0000; bus.b = 16'h1234; end
    @(posedge clk);
    #1 begin bus.a = 16'h1234; bus.b = 16'h1234; end
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("busy_start done c4", {31'd0, bus.done},    1);
    check("busy_start result",  {29'd0, bus.result},  {29'd0, CMP_GT});
    check("busy_start nib_cnt", {27'd0, bus.nib_cnt}, 3);
    repeat (5) @(negedge clk);
    check("busy_start one done", done_cnt - d0, 1);
    check("busy_start idle",     {31'd0, bus.busy}, 0);

    // Reset in cycle 2 aborts immediately.
    d0        = done_cnt;
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort busy",    {31'd0, bus.busy},    0);
    check("abort done",    {31'd0, bus.done},    0);
    check("abort result",  {29'd0, bus.result},  {29'd0, CMP_NONE});
    check("abort nib_cnt", {27'd0, bus.nib_cnt}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort no done", done_cnt - d0, 0);
    run("after_rst", 16'hFFFF, 16'hFFFF, CMP_EQ, 4);

    // Back-to-back: next start in the cycle right after done.
    run("b2b", 16'h0000, 16'hF000, CMP_LT, 1);

    // Sweep: mix of random, equal and single-nibble differences.
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 16'($urandom);
        1: rb = ra;
        default: begin
          rb = ra;
          p  = $urandom_range(0, NIBBLES - 1);
          rb[4*p +: 4] = rb[4*p +: 4] ^ 4'($urandom_range(1, 15));
        end
      endcase
      ref_model(ra, rb, eres, ek);
      run("sweep", ra, rb, eres, ek);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
